// File: rtl/core_axi_master_if.sv
// AXI3 single-beat channel bundle between core_axi_master and the system interconnect.
interface core_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [3:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_valid;
  logic                aw_ready;
  logic [ID_W-1:0]     w_id;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;
  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [3:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output w_id, w_data, w_strb, w_last, w_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  w_id, w_data, w_strb, w_last, w_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/core_axi_master.sv
// Registered single-outstanding AXI3 master for the core's fetch and data ports.
// Optional watchdog with DRAIN recovery is enabled by defining AXI_TIMEOUT_EN.
module core_axi_master #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              ID_W        = 4,
  parameter logic [ID_W-1:0] INST_ID     = 4'b1000,
  parameter logic [ID_W-1:0] DATA_ID     = 4'b0000,
  parameter int              TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   inst,
  output logic                inst_stall,
  output logic                inst_access_fault,
  input  logic                req_mem,
  input  logic                wmem,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_o,
  input  logic [DATA_W/8-1:0] wmask,
  output logic [DATA_W-1:0]   data_i,
  output logic                data_stall,
  output logic                data_err,
  core_axi_master_if.master   axi
);
  localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
`ifdef AXI_TIMEOUT_EN
    , DRAIN = 3'd6
`endif
  } state_t;

  state_t              state_r, next_state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r, inst_r, data_i_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic [ID_W-1:0]     id_r;
  logic                is_wr_r, is_inst_r;
  logic                ar_done_r, aw_done_r, w_done_r;
  logic                ar_valid_r, aw_valid_r, w_valid_r, r_ready_r, b_ready_r;
  logic                inst_done_r, data_done_r, inst_fault_r, data_err_r;
  logic                ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s;
  logic                ar_done_s, aw_done_s, w_done_s, id_match_s;
  logic                capture_s, cmpl_err_s, stray_s, timeout_s, expired_s;
  logic                ar_valid_s, aw_valid_s, w_valid_s, r_ready_s, b_ready_s;
  logic                inst_done_s, data_done_s, inst_fault_s, data_err_s;

  assign ar_hs_s    = ar_valid_r & axi.ar_ready;
  assign aw_hs_s    = aw_valid_r & axi.aw_ready;
  assign w_hs_s     = w_valid_r & axi.w_ready;
  assign r_hs_s     = r_ready_r & axi.r_valid;
  assign b_hs_s     = b_ready_r & axi.b_valid;
  assign ar_done_s  = (state_r != IDLE) & (ar_done_r | ar_hs_s);
  assign aw_done_s  = (state_r != IDLE) & (aw_done_r | aw_hs_s);
  assign w_done_s   = (state_r != IDLE) & (w_done_r | w_hs_s);
  assign id_match_s = (axi.r_id == id_r);

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_r;
  logic             to_r;

  // watchdog: cycles spent in the current bus-wait state, plus a sticky timed-out flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      to_r  <= 1'b0;
    end else begin
      if (next_state_s != state_r) cnt_r <= '0;
      else if (state_r inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}) cnt_r <= cnt_r + CNT_W'(1);
      if (state_r == IDLE) to_r <= 1'b0;
      else if (timeout_s) to_r <= 1'b1;
    end
  end
  assign expired_s = (cnt_r >= CNT_W'(TIMEOUT_CYC - 1));
`else
  assign expired_s = 1'b0;
`endif

  // next-state decode with per-cycle completion events
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    cmpl_err_s   = 1'b0;
    stray_s      = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // data access wins: it belongs to an older instruction than the fetch
        if (req_mem) next_state_s = wmem ? WR_REQ : RD_ADDR;
        else if (inst_req) next_state_s = RD_ADDR;
        else next_state_s = IDLE;
      end
      RD_ADDR: begin
        if (ar_hs_s) next_state_s = RD_DATA;
        else if (expired_s) begin next_state_s = DONE; timeout_s = 1'b1; end
        else next_state_s = RD_ADDR;
      end
      RD_DATA: begin
        if (r_hs_s && id_match_s) begin
          next_state_s = DONE;
          capture_s    = 1'b1;
          cmpl_err_s   = (axi.r_resp != 2'b00);
        end else if (r_hs_s) stray_s = 1'b1;
        else if (expired_s) begin next_state_s = DONE; timeout_s = 1'b1; end
        else next_state_s = RD_DATA;
      end
      WR_REQ: begin
        if (aw_done_s && w_done_s) next_state_s = WR_RESP;
        else if (expired_s) begin next_state_s = DONE; timeout_s = 1'b1; end
        else next_state_s = WR_REQ;
      end
      WR_RESP: begin
        if (b_hs_s) begin
          next_state_s = DONE;
          cmpl_err_s   = (axi.b_resp != 2'b00);
        end else if (expired_s) begin next_state_s = DONE; timeout_s = 1'b1; end
        else next_state_s = WR_RESP;
      end
`ifdef AXI_TIMEOUT_EN
      DONE:  next_state_s = to_r ? DRAIN : IDLE;
      DRAIN: begin
        if (is_wr_r ? (aw_done_s && w_done_s && b_hs_s) : (ar_done_s && r_hs_s)) next_state_s = IDLE;
        else next_state_s = DRAIN;
      end
`else
      DONE:  next_state_s = IDLE;
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // next values of the registered bus and core outputs, decoded from the next state
  always_comb begin
    ar_valid_s  = 1'b0;
    aw_valid_s  = 1'b0;
    w_valid_s   = 1'b0;
    r_ready_s   = 1'b0;
    b_ready_s   = 1'b0;
    inst_done_s = 1'b0;
    data_done_s = 1'b0;
    case (next_state_s)
      RD_ADDR: ar_valid_s = 1'b1;
      RD_DATA: r_ready_s  = 1'b1;
      WR_REQ: begin
        aw_valid_s = ~aw_done_s;
        w_valid_s  = ~w_done_s;
      end
      WR_RESP: b_ready_s = 1'b1;
      DONE: begin
        inst_done_s = is_inst_r;
        data_done_s = ~is_inst_r;
        // after a timeout, requests already offered must stay up until accepted
        ar_valid_s  = ~is_wr_r & ~ar_done_s;
        aw_valid_s  = is_wr_r & ~aw_done_s;
        w_valid_s   = is_wr_r & ~w_done_s;
      end
`ifdef AXI_TIMEOUT_EN
      DRAIN: begin
        ar_valid_s = ~is_wr_r & ~ar_done_s;
        aw_valid_s = is_wr_r & ~aw_done_s;
        w_valid_s  = is_wr_r & ~w_done_s;
        r_ready_s  = ~is_wr_r;
        b_ready_s  = is_wr_r;
      end
`endif
      default: ar_valid_s = 1'b0;
    endcase
    inst_fault_s = inst_done_s & (cmpl_err_s | timeout_s);
    data_err_s   = (data_done_s & (cmpl_err_s | timeout_s)) | stray_s;
  end

  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      ar_valid_r   <= 1'b0;
      aw_valid_r   <= 1'b0;
      w_valid_r    <= 1'b0;
      r_ready_r    <= 1'b0;
      b_ready_r    <= 1'b0;
      inst_done_r  <= 1'b0;
      data_done_r  <= 1'b0;
      inst_fault_r <= 1'b0;
      data_err_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      ar_valid_r   <= ar_valid_s;
      aw_valid_r   <= aw_valid_s;
      w_valid_r    <= w_valid_s;
      r_ready_r    <= r_ready_s;
      b_ready_r    <= b_ready_s;
      inst_done_r  <= inst_done_s;
      data_done_r  <= data_done_s;
      inst_fault_r <= inst_fault_s;
      data_err_r   <= data_err_s;
    end
  end

  // request capture while idle, handshake bookkeeping and returned data
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      id_r      <= '0;
      is_wr_r   <= 1'b0;
      is_inst_r <= 1'b0;
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      inst_r    <= '0;
      data_i_r  <= '0;
    end else begin
      ar_done_r <= ar_done_s;
      aw_done_r <= aw_done_s;
      w_done_r  <= w_done_s;
      if (state_r == IDLE) begin
        addr_r    <= req_mem ? addr : pc;
        wdata_r   <= data_o;
        wstrb_r   <= wmask;
        id_r      <= req_mem ? DATA_ID : INST_ID;
        is_wr_r   <= req_mem & wmem;
        is_inst_r <= ~req_mem;
      end
      if (capture_s || timeout_s) begin
        if (is_inst_r) inst_r <= capture_s ? axi.r_data : '0;
        else data_i_r <= capture_s ? axi.r_data : '0;
      end
    end
  end

  assign axi.aw_id     = DATA_ID;
  assign axi.aw_addr   = addr_r;
  assign axi.aw_len    = 4'd0;
  assign axi.aw_size   = AXI_SIZE;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_valid  = aw_valid_r;
  assign axi.w_id      = DATA_ID;
  assign axi.w_data    = wdata_r;
  assign axi.w_strb    = wstrb_r;
  assign axi.w_last    = 1'b1;
  assign axi.w_valid   = w_valid_r;
  assign axi.b_ready   = b_ready_r;
  assign axi.ar_id     = id_r;
  assign axi.ar_addr   = addr_r;
  assign axi.ar_len    = 4'd0;
  assign axi.ar_size   = AXI_SIZE;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_valid  = ar_valid_r;
  assign axi.r_ready   = r_ready_r;

  assign inst              = inst_r;
  assign inst_stall        = inst_req & ~inst_done_r;
  assign inst_access_fault = inst_fault_r;
  assign data_i            = data_i_r;
  assign data_stall        = req_mem & ~data_done_r;
  assign data_err          = data_err_r;
endmodule

// File: tb/tb_core_axi_master.sv
// Directed cycle-by-cycle bench for core_axi_master: fetch, store, contention, errors, reset.
module tb_core_axi_master;
  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_stall;
  logic        inst_access_fault;
  logic        req_mem;
  logic        wmem;
  logic [31:0] addr;
  logic [31:0] data_o;
  logic [3:0]  wmask;
  logic [31:0] data_i;
  logic        data_stall;
  logic        data_err;

  int n_cmp = 0;
  int n_bad = 0;

  core_axi_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  core_axi_master dut (
    .clk               (clk),
    .reset             (reset),
    .inst_req          (inst_req),
    .pc                (pc),
    .inst              (inst),
    .inst_stall        (inst_stall),
    .inst_access_fault (inst_access_fault),
    .req_mem           (req_mem),
    .wmem              (wmem),
    .addr              (addr),
    .data_o            (data_o),
    .wmask             (wmask),
    .data_i            (data_i),
    .data_stall        (data_stall),
    .data_err          (data_err),
    .axi               (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one active edge, then settle at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; inst_req = 1'b0; pc = 32'h0; req_mem = 1'b0; wmem = 1'b0;
    addr = 32'h0; data_o = 32'h0; wmask = 4'h0;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_id = 4'h0; axi.b_resp = 2'b00;
    axi.b_valid = 1'b0; axi.ar_ready = 1'b0; axi.r_id = 4'h0; axi.r_data = 32'h0;
    axi.r_resp = 2'b00; axi.r_last = 1'b1; axi.r_valid = 1'b0;
    inst_req = 1'b1; pc = 32'h100;
    tick(); tick();

    chk("rst_ar_valid", axi.ar_valid, 1'b0);
    chk("rst_aw_valid", axi.aw_valid, 1'b0);
    chk("rst_w_valid", axi.w_valid, 1'b0);
    chk("rst_b_ready", axi.b_ready, 1'b0);
    chk("rst_r_ready", axi.r_ready, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_data_i", data_i, 32'h0);
    chk("rst_fault", inst_access_fault, 1'b0);
    chk("rst_data_err", data_err, 1'b0);
    chk("rst_inst_stall", inst_stall, 1'b1);
    chk("rst_data_stall", data_stall, 1'b0);

    // fetch at 0x100 against a zero-wait slave
    reset = 1'b0; axi.ar_ready = 1'b1;
    tick();
    chk("fetch_ar_valid", axi.ar_valid, 1'b1);
    chk("fetch_ar_addr", axi.ar_addr, 32'h100);
    chk("fetch_ar_id", axi.ar_id, 4'b1000);
    chk("fetch_ar_len", axi.ar_len, 4'd0);
    chk("fetch_ar_size", axi.ar_size, 3'd2);
    chk("fetch_ar_burst", axi.ar_burst, 2'b01);
    chk("fetch_stall_c2", inst_stall, 1'b1);
    tick();
    chk("fetch_r_ready", axi.r_ready, 1'b1);
    chk("fetch_ar_drop", axi.ar_valid, 1'b0);
    chk("fetch_stall_c3", inst_stall, 1'b1);
    axi.r_valid = 1'b1; axi.r_id = 4'b1000; axi.r_data = 32'h00500093; axi.r_resp = 2'b00;
    tick();
    chk("fetch_stall_c4", inst_stall, 1'b0);
    chk("fetch_inst", inst, 32'h00500093);
    chk("fetch_no_fault", inst_access_fault, 1'b0);
    chk("fetch_r_ready_off", axi.r_ready, 1'b0);
    inst_req = 1'b0; axi.r_valid = 1'b0;
    tick();
    chk("fetch_idle_stall", inst_stall, 1'b0);
    chk("fetch_idle_ar", axi.ar_valid, 1'b0);

    // store, W accepted first and AW two cycles later
    req_mem = 1'b1; wmem = 1'b1; addr = 32'h2000; data_o = 32'hDEADBEEF; wmask = 4'b0011;
    axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b1;
    tick();
    chk("st_aw_valid", axi.aw_valid, 1'b1);
    chk("st_w_valid", axi.w_valid, 1'b1);
    chk("st_aw_addr", axi.aw_addr, 32'h2000);
    chk("st_aw_id", axi.aw_id, 4'b0000);
    chk("st_w_id", axi.w_id, 4'b0000);
    chk("st_w_data", axi.w_data, 32'hDEADBEEF);
    chk("st_w_strb", axi.w_strb, 4'b0011);
    chk("st_w_last", axi.w_last, 1'b1);
    chk("st_aw_size", axi.aw_size, 3'd2);
    chk("st_ar_idle", axi.ar_valid, 1'b0);
    chk("st_stall", data_stall, 1'b1);
    addr = 32'h5555_0000; data_o = 32'h0; wmask = 4'hF;
    tick();
    chk("st_w_drop", axi.w_valid, 1'b0);
    chk("st_aw_hold", axi.aw_valid, 1'b1);
    axi.w_ready = 1'b0;
    tick();
    chk("st_aw_hold2", axi.aw_valid, 1'b1);
    chk("st_aw_addr_kept", axi.aw_addr, 32'h2000);
    chk("st_w_strb_kept", axi.w_strb, 4'b0011);
    chk("st_b_ready_early", axi.b_ready, 1'b0);
    axi.aw_ready = 1'b1;
    tick();
    chk("st_aw_drop", axi.aw_valid, 1'b0);
    chk("st_b_ready", axi.b_ready, 1'b1);
    chk("st_stall_resp", data_stall, 1'b1);
    axi.aw_ready = 1'b0; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
    tick();
    chk("st_stall_done", data_stall, 1'b0);
    chk("st_no_err", data_err, 1'b0);
    chk("st_b_ready_off", axi.b_ready, 1'b0);
    req_mem = 1'b0; wmem = 1'b0; axi.b_valid = 1'b0;
    tick();
    chk("st_idle_err", data_err, 1'b0);

    // fetch and load raised together: load goes first
    inst_req = 1'b1; pc = 32'h400; req_mem = 1'b1; wmem = 1'b0; addr = 32'h3000;
    tick();
    chk("ct_ar_valid", axi.ar_valid, 1'b1);
    chk("ct_ar_addr", axi.ar_addr, 32'h3000);
    chk("ct_ar_id", axi.ar_id, 4'b0000);
    chk("ct_inst_stall", inst_stall, 1'b1);
    chk("ct_data_stall", data_stall, 1'b1);
    axi.ar_ready = 1'b1;
    tick();
    chk("ct_r_ready", axi.r_ready, 1'b1);
    axi.r_valid = 1'b1; axi.r_id = 4'b0000; axi.r_data = 32'h12345678; axi.r_resp = 2'b00;
    tick();
    chk("ct_data_stall_low", data_stall, 1'b0);
    chk("ct_data_i", data_i, 32'h12345678);
    chk("ct_inst_still_stalled", inst_stall, 1'b1);
    chk("ct_no_err", data_err, 1'b0);
    req_mem = 1'b0; axi.r_valid = 1'b0;
    tick();
    chk("ct_gap_ar", axi.ar_valid, 1'b0);
    tick();
    chk("ct_fetch_ar_valid", axi.ar_valid, 1'b1);
    chk("ct_fetch_ar_addr", axi.ar_addr, 32'h400);
    chk("ct_fetch_ar_id", axi.ar_id, 4'b1000);
    tick();
    chk("ct_fetch_r_ready", axi.r_ready, 1'b1);
    // response tagged with the wrong ID is swallowed and flagged
    axi.r_valid = 1'b1; axi.r_id = 4'b0000; axi.r_data = 32'h11111111; axi.r_resp = 2'b00;
    tick();
    chk("stray_data_err", data_err, 1'b1);
    chk("stray_inst_stall", inst_stall, 1'b1);
    chk("stray_inst_kept", inst, 32'h00500093);
    chk("stray_no_fault", inst_access_fault, 1'b0);
    chk("stray_r_ready", axi.r_ready, 1'b1);
    axi.r_id = 4'b1000; axi.r_data = 32'hCAFEF00D; axi.r_resp = 2'b10;
    tick();
    chk("slverr_stall_low", inst_stall, 1'b0);
    chk("slverr_fault", inst_access_fault, 1'b1);
    chk("slverr_data_err", data_err, 1'b0);
    chk("slverr_inst", inst, 32'hCAFEF00D);
    inst_req = 1'b0; axi.r_valid = 1'b0; axi.r_resp = 2'b00;
    tick();
    chk("slverr_fault_pulse", inst_access_fault, 1'b0);

    // store answered with DECERR, AW and W accepted in the same cycle
    req_mem = 1'b1; wmem = 1'b1; addr = 32'h2004; data_o = 32'h0BADF00D; wmask = 4'b1111;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
    tick();
    chk("de_aw_valid", axi.aw_valid, 1'b1);
    chk("de_w_valid", axi.w_valid, 1'b1);
    chk("de_w_strb", axi.w_strb, 4'b1111);
    tick();
    chk("de_aw_drop", axi.aw_valid, 1'b0);
    chk("de_w_drop", axi.w_valid, 1'b0);
    chk("de_b_ready", axi.b_ready, 1'b1);
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b1; axi.b_resp = 2'b11;
    tick();
    chk("de_data_err", data_err, 1'b1);
    chk("de_stall_low", data_stall, 1'b0);
    req_mem = 1'b0; wmem = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    tick();
    chk("de_err_pulse", data_err, 1'b0);

    // reset while a read response is pending
    inst_req = 1'b1; pc = 32'h800; axi.ar_ready = 1'b1;
    tick();
    tick();
    chk("mr_r_ready", axi.r_ready, 1'b1);
    axi.r_valid = 1'b1; axi.r_id = 4'b1000; axi.r_data = 32'hFFFFFFFF; reset = 1'b1;
    tick();
    chk("mr_ar_valid", axi.ar_valid, 1'b0);
    chk("mr_r_ready_off", axi.r_ready, 1'b0);
    chk("mr_inst_cleared", inst, 32'h0);
    chk("mr_no_fault", inst_access_fault, 1'b0);
    chk("mr_stall", inst_stall, 1'b1);
    reset = 1'b0; inst_req = 1'b0;
    tick();
    chk("mr_r_ready_idle", axi.r_ready, 1'b0);
    chk("mr_ar_idle", axi.ar_valid, 1'b0);
    chk("mr_late_ignored", inst, 32'h0);
    axi.r_valid = 1'b0; inst_req = 1'b1; pc = 32'h900;
    tick();
    chk("mr_restart_ar", axi.ar_valid, 1'b1);
    chk("mr_restart_addr", axi.ar_addr, 32'h900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
